// File: rtl/uart_tx_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_tx_scheduler
//
// Shares one uart transmitter among G_NUM_REQ word producers. Requesters offer
// words on a valid/ready handshake. A round-robin arbiter picks one in IDLE, the
// word is launched with a one-cycle o_tx_en pulse, and the block then follows
// the transmitter's busy flag until the frame completes. If the transmitter
// never raises busy after a launch, o_err pulses and the word is dropped.
//
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_req_valid       per-requester word valid
//   i_req_data        packed words, requester k at [k*W +: W]
//   o_req_ready       one-hot accept strobe (combinational, IDLE only)
//   o_tx_en           launch pulse to the transmitter
//   o_tx_data         word to the transmitter, stable from accept to next accept
//   i_tx_busy         transmitter busy flag
//   o_grant_id        index of the requester owning the transmitter
//   o_active          high whenever the FSM is not IDLE
//   o_err             one-cycle pulse on launch-acknowledge timeout
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
    parameter int G_NUM_REQ     = 4,
    parameter int G_WORD_WIDTH  = 8,
    parameter int G_ACK_TIMEOUT = 15
) (
    input  logic                                        i_clk,
    input  logic                                        i_rst,
    input  logic [G_NUM_REQ-1:0]                        i_req_valid,
    input  logic [G_NUM_REQ*G_WORD_WIDTH-1:0]           i_req_data,
    output logic [G_NUM_REQ-1:0]                        o_req_ready,
    output logic                                        o_tx_en,
    output logic [G_WORD_WIDTH-1:0]                     o_tx_data,
    input  logic                                        i_tx_busy,
    output logic [((G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1)-1:0] o_grant_id,
    output logic                                        o_active,
    output logic                                        o_err
);

    localparam int ID_W  = (G_NUM_REQ > 1) ? $clog2(G_NUM_REQ) : 1;
    localparam int CNT_W = $clog2(G_ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(G_ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT_ACK,
        S_WAIT_DONE
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic [ID_W-1:0]         last_id;
    logic [ID_W-1:0]         winner;
    logic [ID_W-1:0]         cand;
    logic                    found;
    logic [G_WORD_WIDTH-1:0] sel_data;
    logic [CNT_W-1:0]        ack_cnt;
    logic                    accept;
    logic                    ack_timeout;
    logic                    frame_end;

    // Round-robin search starting just after the last served requester.
    always_comb begin
        // NOTE: every variable assigned in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < G_NUM_REQ; i++) begin
            cand = ID_W'((int'(last_id) + 1 + i) % G_NUM_REQ);
            if (!found && i_req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    // Word mux with constant slices only.
    always_comb begin
        sel_data = '0;
        for (int k = 0; k < G_NUM_REQ; k++) begin
            if (winner == ID_W'(k)) begin
                sel_data = i_req_data[k*G_WORD_WIDTH +: G_WORD_WIDTH];
            end
        end
    end

    assign accept      = (state == S_IDLE) && found && !i_tx_busy;
    assign ack_timeout = (state == S_WAIT_ACK) && !i_tx_busy && (ack_cnt == ACK_LAST);
    assign frame_end   = (state == S_WAIT_DONE) && !i_tx_busy;

    // State register.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (accept) state_next = S_LAUNCH;
            S_LAUNCH:    state_next = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (i_tx_busy)        state_next = S_WAIT_DONE;
                else if (ack_timeout) state_next = S_IDLE;
            end
            S_WAIT_DONE: if (!i_tx_busy) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    // Datapath: captured word/grant, RR pointer, ack counter, error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_tx_data  <= '0;
            o_grant_id <= '0;
            last_id    <= ID_W'(G_NUM_REQ - 1);
            ack_cnt    <= '0;
            o_err      <= 1'b0;
        end else begin
            o_err <= ack_timeout;
            if (accept) begin
                o_tx_data  <= sel_data;
                o_grant_id <= winner;
            end
            // Pointer advances only once the frame is finished or abandoned,
            // so a dropped word still counts as that requester's turn.
            if (ack_timeout || frame_end) begin
                last_id <= o_grant_id;
            end
            // Counter runs only while waiting for busy; cleared everywhere else
            // so it is zero on WAIT_ACK entry.
            if ((state == S_WAIT_ACK) && !i_tx_busy) begin
                ack_cnt <= ack_cnt + CNT_W'(1);
            end else begin
                ack_cnt <= '0;
            end
        end
    end

    // Outputs decoded from the state register; o_tx_en is therefore glitch-free
    // and lasts exactly the single LAUNCH cycle.
    always_comb begin
        o_req_ready = '0;
        o_tx_en     = (state == S_LAUNCH);
        o_active    = (state != S_IDLE);
        if (accept && !i_rst) begin
            o_req_ready[winner] = 1'b1;
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
//
// Directed bench for uart_tx_scheduler. Requesters are driven from a table of
// words; a transmitter stand-in raises busy for FRAME cycles after each launch
// (a shortened frame), or busy can be forced to a fixed level. Expected
// (grant, word) pairs are pushed in launch order and a separate monitor pops
// and compares them whenever o_tx_en is seen.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int T     = 15;
    localparam int FRAME = 12;

    logic           i_clk = 1'b0;
    logic           i_rst;
    logic [N-1:0]   i_req_valid;
    logic [N*W-1:0] i_req_data;
    logic [N-1:0]   o_req_ready;
    logic           o_tx_en;
    logic [W-1:0]   o_tx_data;
    logic           i_tx_busy;
    logic [1:0]     o_grant_id;
    logic           o_active;
    logic           o_err;

    uart_tx_scheduler #(
        .G_NUM_REQ    (N),
        .G_WORD_WIDTH (W),
        .G_ACK_TIMEOUT(T)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_req_valid(i_req_valid),
        .i_req_data (i_req_data),
        .o_req_ready(o_req_ready),
        .o_tx_en    (o_tx_en),
        .o_tx_data  (o_tx_data),
        .i_tx_busy  (i_tx_busy),
        .o_grant_id (o_grant_id),
        .o_active   (o_active),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    exp_t       mon_e;
    int         checks = 0;
    int         errors = 0;

    // Transmitter stand-in and requester tables.
    logic       stub_en;
    logic       stub_val;
    int         model_cnt;
    logic [7:0] words [N][3];
    int         n_words [N];
    int         w_idx [N];
    bit         pend [N];

    // Per-cycle bookkeeping.
    int         cyc;
    int         ready_pulses;
    int         err_pulses;
    int         gap_checks;
    int         fall_cyc;
    int         early;
    int         nwait;
    bit         fall_valid;
    bit         gap_chk;
    bit         fell;
    bit         prev_busy;

    assign i_tx_busy = stub_en ? stub_val : (model_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
        end
    endtask

    function automatic bit busy_now();
        return stub_en ? stub_val : (model_cnt != 0);
    endfunction

    function automatic bit producers_done();
        bit d = 1'b1;
        for (int k = 0; k < N; k++) begin
            if (w_idx[k] < n_words[k] || pend[k]) d = 1'b0;
        end
        return d;
    endfunction

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (w_idx[k] < n_words[k]) begin
                i_req_valid[k]       = 1'b1;
                i_req_data[k*W +: W] = words[k][w_idx[k]];
            end else begin
                i_req_valid[k]       = 1'b0;
                i_req_data[k*W +: W] = '0;
            end
        end
    endtask

    task automatic load(input int k, input int n, input logic [7:0] w0,
                        input logic [7:0] w1, input logic [7:0] w2);
        n_words[k]  = n;
        w_idx[k]    = 0;
        words[k][0] = w0;
        words[k][1] = w1;
        words[k][2] = w2;
        drive();
    endtask

    task automatic push(input logic [1:0] id, input logic [7:0] data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    // One clock cycle, entered and left on a falling edge. The handshake is
    // sampled 1 ns before the rising edge; inputs and the transmitter stand-in
    // are updated on the falling edge.
    task automatic step();
        #4;
        for (int k = 0; k < N; k++) pend[k] = o_req_ready[k] && i_req_valid[k];
        if (o_req_ready != '0) begin
            ready_pulses++;
            check("ready_onehot", 32'($onehot(o_req_ready)), 32'd1);
        end
        @(negedge i_clk);
        cyc++;
        for (int k = 0; k < N; k++) begin
            if (pend[k]) begin
                w_idx[k]++;
                pend[k] = 1'b0;
            end
        end
        drive();
        if (o_err) err_pulses++;
        if (o_tx_en && gap_chk && fall_valid) begin
            check("busy_low_to_launch_gap", cyc - fall_cyc, 32'd2);
            gap_checks++;
            fall_valid = 1'b0;
        end
        if (o_tx_en) model_cnt = FRAME;
        else if (model_cnt > 0) model_cnt--;
        fell = prev_busy && !busy_now();
        if (fell) begin
            fall_cyc   = cyc;
            fall_valid = 1'b1;
        end
        prev_busy = busy_now();
    endtask

    task automatic wait_launch(input string name, input int budget);
        int n;
        n = 0;
        while (!o_tx_en && n < budget) begin
            step();
            n++;
        end
        check({name, "_launch_seen"}, o_tx_en, 32'd1);
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        bit done;
        n    = 0;
        done = 1'b0;
        while (!done && n < budget) begin
            step();
            n++;
            done = (sb.size() == 0) && !o_active && !busy_now() && producers_done();
        end
        check({name, "_drained"}, done, 32'd1);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst      = 1'b0;
        fall_valid = 1'b0;
    endtask

    // Scoreboard monitor: every launch must match the next expected entry.
    always @(negedge i_clk) begin
        if (o_tx_en === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_launch", 32'd1, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check("grant_id", o_grant_id, mon_e.id);
                check("tx_data", o_tx_data, mon_e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst        = 1'b1;
        stub_en      = 1'b0;
        stub_val     = 1'b0;
        model_cnt    = 0;
        i_req_valid  = '0;
        i_req_data   = '0;
        cyc          = 0;
        ready_pulses = 0;
        err_pulses   = 0;
        gap_checks   = 0;
        fall_valid   = 1'b0;
        gap_chk      = 1'b0;
        fell         = 1'b0;
        prev_busy    = 1'b0;
        for (int k = 0; k < N; k++) begin
            n_words[k] = 0;
            w_idx[k]   = 0;
            pend[k]    = 1'b0;
        end
        @(negedge i_clk);

        // Reset values, with req0 already valid: ready must stay low in reset.
        load(0, 1, 8'hA5, 8'h00, 8'h00);
        step();
        step();
        step();
        check("rst_tx_en", o_tx_en, 32'd0);
        check("rst_tx_data", o_tx_data, 32'd0);
        check("rst_grant_id", o_grant_id, 32'd0);
        check("rst_active", o_active, 32'd0);
        check("rst_err", o_err, 32'd0);
        check("rst_ready", o_req_ready, 32'd0);

        // Single word from req0: one ready pulse, launch, busy in WAIT_ACK,
        // o_active drops one cycle after busy falls.
        push(2'd0, 8'hA5);
        ready_pulses = 0;
        i_rst        = 1'b0;
        wait_launch("t1", 20);
        check("t1_ready_pulses", ready_pulses, 32'd1);
        step();
        check("t1_tx_en_one_cycle", o_tx_en, 32'd0);
        check("t1_busy_in_wait_ack", busy_now(), 32'd1);
        nwait = 0;
        while (!fell && nwait < 100) begin
            step();
            nwait++;
        end
        check("t1_busy_fell", fell, 32'd1);
        check("t1_active_at_busy_low", o_active, 32'd1);
        step();
        check("t1_active_after_busy_low", o_active, 32'd0);
        wait_drain("t1", 50);

        // All four continuously valid: strict 0,1,2,3 rotation twice.
        do_reset();
        ready_pulses = 0;
        load(0, 2, 8'h10, 8'h10, 8'h00);
        load(1, 2, 8'h21, 8'h21, 8'h00);
        load(2, 2, 8'h32, 8'h32, 8'h00);
        load(3, 2, 8'h43, 8'h43, 8'h00);
        for (int r = 0; r < 2; r++) begin
            push(2'd0, 8'h10);
            push(2'd1, 8'h21);
            push(2'd2, 8'h32);
            push(2'd3, 8'h43);
        end
        wait_drain("t2", 400);
        check("t2_ready_pulses", ready_pulses, 32'd8);

        // Single requester re-granted each frame, 2-cycle busy-low to launch.
        do_reset();
        gap_checks = 0;
        gap_chk    = 1'b1;
        load(2, 3, 8'h01, 8'h02, 8'h03);
        push(2'd2, 8'h01);
        push(2'd2, 8'h02);
        push(2'd2, 8'h03);
        wait_drain("t3", 300);
        gap_chk = 1'b0;
        check("t3_gap_checks", gap_checks, 32'd2);

        // Transmitter never acknowledges: o_err exactly T cycles after WAIT_ACK
        // entry, word dropped, pointer moves on to req2 then back to req1.
        do_reset();
        stub_en    = 1'b1;
        stub_val   = 1'b0;
        err_pulses = 0;
        load(1, 2, 8'h7E, 8'h7F, 8'h00);
        load(2, 1, 8'h55, 8'h00, 8'h00);
        push(2'd1, 8'h7E);
        push(2'd2, 8'h55);
        push(2'd1, 8'h7F);
        wait_launch("t4", 20);
        early = 0;
        repeat (T) begin
            step();
            if (o_err) early++;
        end
        step();
        check("t4_err_at_timeout", o_err, 32'd1);
        check("t4_no_early_err", early, 32'd0);
        check("t4_idle_at_err", o_active, 32'd0);
        wait_drain("t4", 200);
        check("t4_err_pulses", err_pulses, 32'd3);
        stub_en    = 1'b0;
        err_pulses = 0;

        // Busy held high in IDLE: nothing accepted until it drops.
        do_reset();
        stub_en      = 1'b1;
        stub_val     = 1'b1;
        ready_pulses = 0;
        load(0, 1, 8'h3C, 8'h00, 8'h00);
        push(2'd0, 8'h3C);
        repeat (10) step();
        check("t5_no_ready_while_busy", ready_pulses, 32'd0);
        check("t5_still_idle", o_active, 32'd0);
        stub_en = 1'b0;
        wait_drain("t5", 100);
        check("t5_ready_after_busy", ready_pulses, 32'd1);

        // Reset during WAIT_DONE, then the first grant returns to req0.
        do_reset();
        load(1, 1, 8'h99, 8'h00, 8'h00);
        push(2'd1, 8'h99);
        wait_launch("t6", 20);
        step();
        step();
        check("t6_in_wait_done", o_active, 32'd1);
        i_rst = 1'b1;
        step();
        check("t6_rst_active", o_active, 32'd0);
        check("t6_rst_tx_en", o_tx_en, 32'd0);
        check("t6_rst_err", o_err, 32'd0);
        check("t6_rst_ready", o_req_ready, 32'd0);
        load(0, 1, 8'h11, 8'h00, 8'h00);
        load(1, 1, 8'h22, 8'h00, 8'h00);
        push(2'd0, 8'h11);
        push(2'd1, 8'h22);
        step();
        i_rst      = 1'b0;
        fall_valid = 1'b0;
        wait_drain("t6", 200);

        check("sb_empty", sb.size(), 32'd0);
        check("no_err_when_acked", err_pulses, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
